// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable sequencer: free-run / single-step / halt control driven by a synchronized clk_div.
// Optional macro STEP_CNT_EN adds a 16-bit wrapping count of issued cpu_ce pulses.
//
// state  | meaning
// IDLE   | waiting; no cpu_ce; debounced press enters STEP, run_mode enters RUN
// STEP   | issue exactly one cpu_ce on the next tick, then back to IDLE
// RUN    | one cpu_ce per tick while run_mode=1
// HALTED | halt requested; leave only when halt=0 and run_mode=0
module cpu_step_ctrl #(
    parameter int unsigned DEB_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_div,
    input  logic        run_mode,
    input  logic        step_btn,
    input  logic        halt,
    output logic        cpu_ce,
    output logic [1:0]  state_o,
    output logic [15:0] step_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STEP   = 2'b01,
        RUN    = 2'b10,
        HALTED = 2'b11
    } state_t;

    localparam logic [3:0] DEB_LAST = 4'(DEB_TICKS - 1);

    logic       div_s1_q, div_s2_q, div_hist_q;
    logic       btn_s1_q, btn_s2_q;
    logic [1:0] arm_q;
    logic       armed;
    logic       tick;

    logic       btn_db_q, btn_db_d;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic       press_q, press_d;

    state_t     state_q;
    logic       cpu_ce_q;

    // arm_q holds off tick and press until the synchronizers and history
    // flop carry real samples, so levels present at reset release are not edges.
    assign armed = (arm_q == 2'd3);
    assign tick  = div_s2_q & ~div_hist_q & armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_s1_q   <= 1'b0;
            div_s2_q   <= 1'b0;
            div_hist_q <= 1'b0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            arm_q      <= 2'd0;
        end else begin
            div_s1_q   <= clk_div;
            div_s2_q   <= div_s1_q;
            div_hist_q <= div_s2_q;
            btn_s1_q   <= step_btn;
            btn_s2_q   <= btn_s1_q;
            if (!armed) begin
                arm_q <= arm_q + 2'd1;
            end
        end
    end

    // While unarmed, btn_db follows the synchronized button so a button held
    // through reset is absorbed without producing a press.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        btn_db_d  = btn_db_q;
        press_d   = 1'b0;
        if (!armed) begin
            btn_db_d  = btn_s2_q;
            deb_cnt_d = 4'd0;
        end else if (tick) begin
            if (btn_s2_q == btn_db_q) begin
                deb_cnt_d = 4'd0;
            end else if (deb_cnt_q == DEB_LAST) begin
                btn_db_d  = btn_s2_q;
                deb_cnt_d = 4'd0;
                press_d   = btn_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db_q  <= 1'b0;
            deb_cnt_q <= 4'd0;
            press_q   <= 1'b0;
        end else begin
            btn_db_q  <= btn_db_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
        end
    end

    // press_q is a single-cycle pulse consumed only in IDLE, so presses seen
    // in any other state are dropped rather than queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cpu_ce_q <= 1'b0;
        end else begin
            cpu_ce_q <= tick & ~halt & ((state_q == RUN) | (state_q == STEP));
            case (state_q)
                IDLE: begin
                    if (halt)          state_q <= HALTED;
                    else if (run_mode) state_q <= RUN;
                    else if (press_q)  state_q <= STEP;
                end
                RUN: begin
                    if (halt)           state_q <= HALTED;
                    else if (!run_mode) state_q <= IDLE;
                end
                STEP: begin
                    if (halt)      state_q <= HALTED;
                    else if (tick) state_q <= IDLE;
                end
                HALTED: begin
                    if (!halt && !run_mode) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ce  = cpu_ce_q;
    assign state_o = state_q;

`ifdef STEP_CNT_EN
    logic [15:0] step_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= 16'h0000;
        end else if (cpu_ce_q) begin
            step_cnt_q <= step_cnt_q + 16'd1;
        end
    end

    assign step_cnt = step_cnt_q;
`else
    assign step_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: directed clk_div periods push the expected cpu_ce cycle,
// a negedge monitor pops and compares each observed cpu_ce pulse.
module tb_cpu_step_ctrl;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        clk_div  = 1'b0;
    logic        run_mode = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt     = 1'b0;
    logic        cpu_ce;
    logic [1:0]  state_o;
    logic [15:0] step_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_q[$];

`ifdef STEP_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    cpu_step_ctrl #(.DEB_TICKS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_div  (clk_div),
        .run_mode (run_mode),
        .step_btn (step_btn),
        .halt     (halt),
        .cpu_ce   (cpu_ce),
        .state_o  (state_o),
        .step_cnt (step_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cpu_ce === 1'b1) begin
            int e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ce_unexpected: cpu_ce=1 at cycle %0d, required 0", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e) begin
                    errors++;
                    $display("FAIL ce_cycle: cpu_ce at cycle %0d, required cycle %0d", cyc, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [15:0] n);
        return CNT_ON ? {16'd0, n} : 32'd0;
    endfunction

    // One 10-cycle clk_div period starting at a negedge. clk_div seen at the
    // next posedge (E0) gives tick after E1 and cpu_ce after E2 = cyc+3.
    // act: 0 none, 1 raise halt during tick, 2 drop run_mode during tick.
    task automatic period(input bit exp_ce, input int act);
        if (exp_ce) exp_q.push_back(cyc + 3);
        clk_div = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (act == 1)      halt = 1'b1;
        else if (act == 2) run_mode = 1'b0;
        repeat (3) @(negedge clk);
        clk_div = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Button high for 6 ticks: the 4th tick commits btn_db, STEP is entered,
    // the 5th tick issues the single cpu_ce. Then low long enough to settle.
    task automatic step_once(input string tag);
        step_btn = 1'b1;
        repeat (4) period(1'b0, 0);
        check({tag, "_in_step"}, {30'd0, state_o}, 32'h1);
        period(1'b1, 0);
        check({tag, "_back_idle"}, {30'd0, state_o}, 32'h0);
        period(1'b0, 0);
        step_btn = 1'b0;
        repeat (5) period(1'b0, 0);
        check({tag, "_idle_after"}, {30'd0, state_o}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {30'd0, state_o}, 32'h0);
        check("reset_ce", {31'd0, cpu_ce}, 32'h0);
        check("reset_cnt", {16'd0, step_cnt}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", {30'd0, state_o}, 32'h0);

        run_mode = 1'b1;
        repeat (2) @(negedge clk);
        check("run_state", {30'd0, state_o}, 32'h2);
        repeat (4) period(1'b1, 0);
        check("freerun_cnt", {16'd0, step_cnt}, cnt_exp(16'd4));

        period(1'b1, 2);
        check("run_exit_state", {30'd0, state_o}, 32'h0);

        run_mode = 1'b1;
        repeat (2) @(negedge clk);
        period(1'b1, 0);
        period(1'b0, 1);
        check("halt_state", {30'd0, state_o}, 32'h3);
        halt = 1'b0;
        period(1'b0, 0);
        check("halt_hold_runmode", {30'd0, state_o}, 32'h3);
        run_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("halt_exit_state", {30'd0, state_o}, 32'h0);
        check("halt_cnt", {16'd0, step_cnt}, cnt_exp(16'd6));

        step_once("step");
        check("step_cnt", {16'd0, step_cnt}, cnt_exp(16'd7));

        for (int k = 0; k < 10; k++) begin
            step_btn = (k % 2 == 0);
            period(1'b0, 0);
        end
        step_btn = 1'b0;
        check("bounce_state", {30'd0, state_o}, 32'h0);
        check("bounce_cnt", {16'd0, step_cnt}, cnt_exp(16'd7));

`ifdef STEP_CNT_EN
        force dut.step_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.step_cnt_q;
        @(negedge clk);
        check("wrap_preload", {16'd0, step_cnt}, 32'hFFFF);
`endif
        step_once("wrap");
        check("wrap_cnt", {16'd0, step_cnt}, 32'h0);

        run_mode = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(cyc + 3);
        clk_div = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ce", {31'd0, cpu_ce}, 32'h0);
        check("rst_mid_state", {30'd0, state_o}, 32'h0);
        check("rst_mid_cnt", {16'd0, step_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_release_run", {30'd0, state_o}, 32'h2);
        clk_div = 1'b0;
        repeat (5) @(negedge clk);
        period(1'b1, 0);
        period(1'b1, 0);
        check("rst_after_cnt", {16'd0, step_cnt}, cnt_exp(16'd2));

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors += exp_q.size();
            $display("FAIL ce_missing: %0d expected cpu_ce pulses not seen, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter: DEB_TICKS, default 4, debounce length in clk_div ticks (range 1..15).
REQ-002 clk  input  1  system clock; every flop is on its rising edge.
REQ-003 rst_n  input  1  reset: asynchronous assert, active-low.
REQ-004 clk_div  input  1  divided clock from the upstream divide-by-10 stage; treated as data and synchronized, never used as a clock.
REQ-005 run_mode  input  1  level; 1 = free-run, 0 = single-step.
REQ-006 step_btn  input  1  raw asynchronous step push-button, active-high.
REQ-007 halt  input  1  CPU halt request, level.
REQ-008 cpu_ce  output  1  registered CPU clock-enable pulse, one clk cycle wide.
REQ-009 state_o  output  2  current FSM state encoding.
REQ-010 step_cnt  output  16  count of issued cpu_ce pulses.

Function
REQ-011 clk_div SHALL pass through 2 synchronizer flops plus 1 history flop; tick = sync2 & ~hist, high exactly one clk cycle per clk_div rising edge.
REQ-012 Latency: E0 is the first clk edge sampling clk_div=1. tick SHALL be high in the cycle after E1, and cpu_ce (when enabled) SHALL be high in the cycle after E2.
REQ-013 step_btn SHALL be 2-flop synchronized. The debounce counter SHALL increment on each tick while sync_btn != btn_db and clear on any tick where they match.
REQ-014 When the debounce counter reaches DEB_TICKS, btn_db SHALL take sync_btn and the counter SHALL clear. press = one-cycle pulse on a btn_db 0->1 transition.
REQ-015 FSM states: IDLE=2'b00, STEP=2'b01, RUN=2'b10, HALTED=2'b11; state_o = state.
REQ-016 IDLE transitions:
- halt -> HALTED.
- else run_mode=1 -> RUN.
- else press -> STEP.
- else stay.
REQ-017 RUN: halt -> HALTED; else run_mode=0 -> IDLE; else stay.
REQ-018 STEP: halt -> HALTED; else on tick -> IDLE; else stay. Exactly one cpu_ce is issued per STEP visit.
REQ-019 HALTED: exit to IDLE only when halt=0 and run_mode=0; else stay.
REQ-020 cpu_ce SHALL register tick & ~halt & (state==RUN | state==STEP); never high in IDLE or HALTED.
REQ-021 Presses arriving in RUN, STEP or HALTED SHALL be discarded, not queued.
REQ-022 Simultaneous tick and halt: halt wins, no cpu_ce, next state HALTED.
REQ-023 Simultaneous run_mode 1->0 and tick in RUN: cpu_ce SHALL still issue for that tick, then IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately force:
- state=IDLE, cpu_ce=0, step_cnt=0.
- all synchronizer and history flops=0, btn_db=0, debounce counter=0.
REQ-025 Reset mid-pulse SHALL drop cpu_ce asynchronously. Release SHALL NOT generate a spurious tick or press, even if clk_div=1 or step_btn=1 at release.

Configuration
REQ-026 Macro STEP_CNT_EN:
- Defined: step_cnt increments by 1 in the cycle after each cpu_ce pulse, wraps 16'hFFFF -> 16'h0000.
- Undefined: counter logic omitted and step_cnt tied to 16'h0000.

Verification
REQ-027 Free-run: clk 20 ns, clk_div = clk/10, run_mode=1, halt=0 after reset -> state_o=2'b10; one cpu_ce per 10 clk cycles; first cpu_ce in the cycle after E2.
REQ-028 Single-step: run_mode=0, step_btn held high 6 ticks then low -> exactly 1 cpu_ce; state_o sequence 00->01->00; step_cnt=1 (STEP_CNT_EN defined).
REQ-029 Bounce: step_btn toggled every 1 tick for 10 ticks with DEB_TICKS=4 -> no press, no cpu_ce, state_o stays 2'b00.
REQ-030 Halt: in RUN, assert halt on the cycle tick is high -> no cpu_ce that tick; state_o=2'b11. Deassert halt with run_mode=1 -> stays 11. Set run_mode=0 -> 00.
REQ-031 Wrap: preload/force step_cnt=16'hFFFF, issue one step -> step_cnt=16'h0000. With STEP_CNT_EN undefined -> step_cnt always 0.
REQ-032 Reset mid-operation: pull rst_n low while cpu_ce=1 -> cpu_ce=0 and state_o=00 before the next clk edge. Release with clk_div=1 -> no cpu_ce until the next clk_div rising edge.
